// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: state encodings, default
// parameter values and the select-code stepping helpers.
package scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_GUARD = 1;

  // Next select code, modulo 8, in the latched direction.
  function automatic logic [2:0] step_code(input logic [2:0] code, input logic down);
    return down ? (code - 3'd1) : (code + 3'd1);
  endfunction

  // True when stepping from this code crosses the 7/0 boundary.
  function automatic logic is_wrap(input logic [2:0] code, input logic down);
    return down ? (code == 3'd0) : (code == 3'd7);
  endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/threetoeight.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module threetoeight (
  input  logic [2:0] i,
  input  logic       En,
  output logic [7:0] f
);

  // One-hot decode gated by the enable.
  always_comb begin
    f = 8'h00;
    if (En) f[i] = 1'b1;
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit select code through all eight values with a programmable
// dwell per code, an optional blanking gap, up/down direction and
// one-shot or continuous operation. All outputs are registered.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int GUARD = DEF_GUARD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic          oneshot,
  input  logic [DW-1:0] dwell,
  input  logic          ld,
  input  logic [2:0]    ld_code,
  output logic [2:0]    sel,
  output logic          en,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  localparam bit         HAS_GAP  = (GUARD > 0);
  localparam logic [1:0] GAP_LOAD = HAS_GAP ? 2'(GUARD - 1) : 2'd0;

  state_t        state, state_nxt;
  logic          dir_q, oneshot_q;
  logic [DW-1:0] dload_q;
  logic [2:0]    step_q;

  logic          dc_load, dc_zero, gc_load, gc_zero;
  logic [DW-1:0] dc_val;
  logic          go, advance, last, gap_end;
  logic [2:0]    sel_nxt;
  logic          en_nxt, busy_nxt, done_nxt, wrap_nxt;

  // Counter reload value is dwell-1, with a dwell of zero treated as one.
  function automatic logic [DW-1:0] dwell_reload(input logic [DW-1:0] d);
    return (d == '0) ? '0 : (d - 1'b1);
  endfunction

  assign go      = (state == IDLE) && start && !stop;
  assign advance = (state == ACTIVE) && dc_zero && !stop;
  assign last    = oneshot_q && (step_q == 3'd7);
  assign gap_end = (state == GAP) && gc_zero && !stop;

  dwell_cnt #(.W(DW)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dc_load),
    .load_val (dc_val),
    .dec      (state == ACTIVE),
    .zero     (dc_zero)
  );

  dwell_cnt #(.W(2)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gc_load),
    .load_val (GAP_LOAD),
    .dec      (state == GAP),
    .zero     (gc_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; stop always wins over sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = ACTIVE;
      ACTIVE: begin
        if (stop)         state_nxt = IDLE;
        else if (dc_zero) state_nxt = last ? IDLE : (HAS_GAP ? GAP : ACTIVE);
      end
      GAP: begin
        if (stop)         state_nxt = IDLE;
        else if (gc_zero) state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counter controls.
  always_comb begin
    sel_nxt  = sel;
    done_nxt = 1'b0;
    wrap_nxt = 1'b0;
    dc_load  = 1'b0;
    dc_val   = dload_q;
    gc_load  = 1'b0;
    if (go) begin
      dc_load = 1'b1;
      dc_val  = dwell_reload(dwell);
    end else if ((state == IDLE) && !stop && ld) begin
      sel_nxt = ld_code;
    end
    if (advance) begin
      sel_nxt  = step_code(sel, dir_q);
      wrap_nxt = is_wrap(sel, dir_q);
      done_nxt = last;
      dc_load  = !last && !HAS_GAP;
      gc_load  = !last && HAS_GAP;
    end
    if (gap_end) dc_load = 1'b1;
    en_nxt   = (state_nxt == ACTIVE);
    busy_nxt = (state_nxt != IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel  <= 3'd0;
      en   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
    end else begin
      sel  <= sel_nxt;
      en   <= en_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Sweep configuration is captured at start and frozen until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
      dload_q   <= '0;
      step_q    <= 3'd0;
    end else if (go) begin
      dir_q     <= dir;
      oneshot_q <= oneshot;
      dload_q   <= dwell_reload(dwell);
      step_q    <= 3'd0;
    end else if (advance) begin
      step_q    <= step_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench: two sequencers (gap of one cycle and no gap) each feeding
// a 3-to-8 decoder, driven from shared stimulus.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir, oneshot, ld;
  logic [7:0] dwell;
  logic [2:0] ld_code;

  logic [2:0] sel1, sel0;
  logic       en1, busy1, done1, wrap1, en0, busy0, done0, wrap0;
  logic [7:0] f1, f0;
  logic [14:0] obs1, obs0;

  int vectors = 0;
  int miscompares = 0;

  scan_sequencer #(.DW(8), .GUARD(1)) u_g1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .oneshot(oneshot), .dwell(dwell), .ld(ld), .ld_code(ld_code),
    .sel(sel1), .en(en1), .busy(busy1), .done(done1), .wrap(wrap1)
  );
  threetoeight d_g1 (.i(sel1), .En(en1), .f(f1));

  scan_sequencer #(.DW(8), .GUARD(0)) u_g0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .oneshot(oneshot), .dwell(dwell), .ld(ld), .ld_code(ld_code),
    .sel(sel0), .en(en0), .busy(busy0), .done(done0), .wrap(wrap0)
  );
  threetoeight d_g0 (.i(sel0), .En(en0), .f(f0));

  assign obs1 = {sel1, en1, busy1, done1, wrap1, f1};
  assign obs0 = {sel0, en0, busy0, done0, wrap0, f0};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {sel,en,busy,done,wrap,f}; f is one-hot of sel when enabled.
  function automatic logic [14:0] pk(logic [2:0] s, logic e, logic b, logic d, logic w);
    logic [7:0] f;
    f = 8'h00;
    if (e) f = 8'd1 << s;
    return {s, e, b, d, w, f};
  endfunction

  // Expected GUARD=1, dwell=3 one-shot up sweep from code s: cycle c has
  // code index c/4; position 3 of each period is the gap, already showing
  // the next code.
  function automatic logic [14:0] g1_exp(logic [2:0] s, int c);
    logic [2:0] es;
    int k, pos;
    k   = c / 4;
    pos = c % 4;
    es  = s + 3'(k) + ((pos == 3) ? 3'd1 : 3'd0);
    return pk(es, pos != 3, 1'b1, 1'b0, (pos == 3) && (es == 3'd0));
  endfunction

  task automatic sweep_g1(input logic [2:0] s, input bit disturb);
    dwell = 8'd3; dir = 1'b0; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 31; c++) begin
      chk($sformatf("sweep s%0d c%0d", s, c), obs1, g1_exp(s, c));
      if (disturb && c == 5) begin
        start = 1'b1; ld = 1'b1; ld_code = 3'd6; dwell = 8'd7; dir = 1'b1; oneshot = 1'b0;
      end
      if (disturb && c == 6) begin
        start = 1'b0; ld = 1'b0;
      end
      tick();
    end
    chk($sformatf("done s%0d", s), obs1, pk(s, 1'b0, 1'b0, 1'b1, s == 3'd0));
    tick();
    chk($sformatf("after s%0d", s), obs1, pk(s, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [2:0] es;
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; oneshot = 1'b0;
    ld = 1'b0; dwell = 8'd0; ld_code = 3'd0;
    tick();
    chk("reset g1", obs1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("reset g0", obs0, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    tick();
    chk("idle g1", obs1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start+stop", obs1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // One-shot sweep from 0 with busy-time start/ld/dwell/dir disturbance.
    sweep_g1(3'd0, 1'b1);

    // Asynchronous reset in the middle of a continuous sweep.
    dwell = 8'd3; dir = 1'b0; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("pre-reset", obs1, pk(3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    #3 rst = 1'b1;
    #1 chk("async reset", obs1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post-reset idle c%0d", c), obs1, pk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Stop during the gap after code 2, then resume from 3.
    dwell = 8'd3; dir = 1'b0; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("pre-stop c%0d", c), obs1, g1_exp(3'd0, c));
      if (c == 11) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("stopped", obs1, pk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    chk("stopped hold", obs1, pk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    sweep_g1(3'd3, 1'b0);

    // No-gap instance: load 5, continuous down with dwell 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld = 1'b1; ld_code = 3'd5;
    tick();
    ld = 1'b0;
    chk("ld 5", obs0, pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0));
    dir = 1'b1; dwell = 8'd0; oneshot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 17; c++) begin
      es = 3'd5 - 3'(c);
      chk($sformatf("down c%0d", c), obs0, pk(es, 1'b1, 1'b1, 1'b0, (es == 3'd7) && (c > 0)));
      if (c == 16) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("g0 stopped", obs0, pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
